// File: rtl/pe_row_ctrl_if.sv
// Host-side bundle of the PE row controller: row request (start/row_len/
// kernel_in/bias_in), ifmap sample stream, result stream and status.
//
// Handshake: a sample moves from master to slave on a rising clock edge where
// in_valid and in_ready are both 1. in_data must be stable whenever in_valid
// is 1. The result stream (out_valid/out_data) has no ready: the receiver must
// take every out_valid cycle.
//
// Modports:
//   master - row source / result sink (testbench or upstream logic)
//   slave  - the controller
interface pe_row_ctrl_if #(
  parameter int TAPS    = 3,
  parameter int MAX_ROW = 64
);
  localparam int LW = $clog2(MAX_ROW + 1);

  logic                   start;
  logic [LW-1:0]          row_len;
  logic [TAPS-1:0][7:0]   kernel_in;   // element i is a signed 8-bit weight
  logic signed [31:0]     bias_in;
  logic                   in_valid;
  logic                   in_ready;
  logic signed [7:0]      in_data;
  logic                   out_valid;
  logic signed [31:0]     out_data;
  logic                   busy;
  logic                   done;
  logic                   err;

  modport master (
    output start, row_len, kernel_in, bias_in, in_valid, in_data,
    input  in_ready, out_valid, out_data, busy, done, err
  );

  modport slave (
    input  start, row_len, kernel_in, bias_in, in_valid, in_data,
    output in_ready, out_valid, out_data, busy, done, err
  );
endinterface

// File: rtl/pe_row_ctrl.sv
// Row controller for a 1-D convolution PE. For each accepted row it clears the
// PE, loads the kernel, buffers row_len ifmap samples, replays them to the PE
// back-to-back, and forwards one PE result per complete window.
//
// Ports:
//   clk, rst         - clock, asynchronous active-high reset
//   host             - pe_row_ctrl_if.slave (request, sample stream, results)
//   pe_rst           - PE clear strobe (one cycle, CLEAR state)
//   pe_write_kernel  - PE kernel load strobe (one cycle, KLOAD state)
//   pe_weights       - registered kernel to the PE
//   pe_ifmap         - registered sample to the PE, 0 outside STREAM
//   pe_psum          - registered bias to the PE
//   pe_sum           - PE output sum, PE_LATENCY cycles after its sample
//   dbg_state        - current FSM state encoding
module pe_row_ctrl #(
  parameter int TAPS       = 3,
  parameter int MAX_ROW    = 64,
  parameter int PE_LATENCY = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  pe_row_ctrl_if.slave         host,
  output logic                 pe_rst,
  output logic                 pe_write_kernel,
  output logic [TAPS-1:0][7:0] pe_weights,
  output logic signed [7:0]    pe_ifmap,
  output logic signed [31:0]   pe_psum,
  input  logic signed [31:0]   pe_sum,
  output logic [2:0]           dbg_state
);
  localparam int LW = $clog2(MAX_ROW + 1);
  localparam int AW = $clog2(MAX_ROW);
  localparam int DW = $clog2(PE_LATENCY + 1);
  // One counter serves the FILL/STREAM sample index and the DRAIN countdown.
  localparam int CW = (LW > DW) ? LW : DW;
  localparam logic [LW-1:0] TAPS_L     = LW'(TAPS);
  localparam logic [LW-1:0] MAX_L      = LW'(MAX_ROW);
  localparam logic [CW-1:0] FIRST_WIN  = CW'(TAPS - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(PE_LATENCY);

  typedef enum logic [2:0] {IDLE, CLEAR, KLOAD, FILL, STREAM, DRAIN} state_t;

  state_t             state, state_n;
  logic [CW-1:0]      idx, idx_n;
  logic [LW-1:0]      len_q;
  logic [CW-1:0]      last_idx;
  logic               start_ok, start_bad, fill_fire;
  logic signed [7:0]  rd_sample;
  logic               win_in, last_in;
  // Per-sample tags travelling alongside the PE pipeline; stage k lines up
  // with the sample driven k cycles earlier.
  logic [PE_LATENCY:0] win_dl, last_dl;
  logic                out_valid_q, done_q, err_q;
  logic signed [31:0]  out_data_q;
  logic signed [7:0]   row_buf [MAX_ROW];

  assign last_idx = CW'(len_q) - CW'(1);

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    start_ok  = 1'b0;
    start_bad = 1'b0;
    fill_fire = 1'b0;
    case (state)
      IDLE: begin
        if (host.start) begin
          if (host.row_len >= TAPS_L && host.row_len <= MAX_L) begin
            start_ok = 1'b1;
            state_n  = CLEAR;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      CLEAR: state_n = KLOAD;
      KLOAD: begin
        state_n = FILL;
        idx_n   = '0;
      end
      FILL: begin
        if (host.in_valid) begin
          fill_fire = 1'b1;
          if (idx == last_idx) begin
            state_n = STREAM;
            idx_n   = '0;
          end else begin
            idx_n = idx + CW'(1);
          end
        end
      end
      STREAM: begin
        if (idx == last_idx) begin
          state_n = DRAIN;
          idx_n   = '0;
        end else begin
          idx_n = idx + CW'(1);
        end
      end
      DRAIN: begin
        if (idx == DRAIN_LAST) begin
          state_n = IDLE;
          idx_n   = '0;
        end else begin
          idx_n = idx + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // The first STREAM sample is loaded on the same edge as the last FILL
  // write; for a one-sample row that write is buffer[0], so forward it.
  always_comb begin
    rd_sample = '0;
    if (state == FILL && idx == '0) rd_sample = host.in_data;
    else                            rd_sample = row_buf[idx_n[AW-1:0]];
    win_in  = (state_n == STREAM) && (idx_n >= FIRST_WIN);
    last_in = (state_n == STREAM) && (idx_n == last_idx);
  end

  always_ff @(posedge clk) begin
    if (fill_fire) row_buf[idx[AW-1:0]] <= host.in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      len_q       <= '0;
      pe_weights  <= '0;
      pe_psum     <= '0;
      pe_ifmap    <= '0;
      win_dl      <= '0;
      last_dl     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      err_q <= start_bad;
      if (start_ok) begin
        len_q      <= host.row_len;
        pe_weights <= host.kernel_in;
        pe_psum    <= host.bias_in;
      end else if (state_n == IDLE) begin
        pe_psum <= '0;
      end
      pe_ifmap    <= (state_n == STREAM) ? rd_sample : '0;
      win_dl      <= {win_dl[PE_LATENCY-1:0], win_in};
      last_dl     <= {last_dl[PE_LATENCY-1:0], last_in};
      out_valid_q <= win_dl[PE_LATENCY];
      done_q      <= win_dl[PE_LATENCY] & last_dl[PE_LATENCY];
      if (win_dl[PE_LATENCY]) out_data_q <= pe_sum;
    end
  end

  assign pe_rst          = (state == CLEAR);
  assign pe_write_kernel = (state == KLOAD);
  assign host.in_ready   = (state == FILL);
  assign host.busy       = (state != IDLE);
  assign host.out_valid  = out_valid_q;
  assign host.out_data   = out_data_q;
  assign host.done       = done_q;
  assign host.err        = err_q;
  assign dbg_state       = state;
endmodule

// File: tb/tb_pe_row_ctrl.sv
`timescale 1ns/1ps
module tb_pe_row_ctrl;
  localparam int TAPS       = 3;
  localparam int MAX_ROW    = 64;
  localparam int PE_LATENCY = 5;
  localparam int LW         = $clog2(MAX_ROW + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pe_row_ctrl_if #(.TAPS(TAPS), .MAX_ROW(MAX_ROW)) host ();

  logic                 pe_rst, pe_write_kernel;
  logic [TAPS-1:0][7:0] pe_weights;
  logic signed [7:0]    pe_ifmap;
  logic signed [31:0]   pe_psum, pe_sum;
  logic [2:0]           dbg_state;

  pe_row_ctrl #(.TAPS(TAPS), .MAX_ROW(MAX_ROW), .PE_LATENCY(PE_LATENCY)) dut (
    .clk             (clk),
    .rst             (rst),
    .host            (host),
    .pe_rst          (pe_rst),
    .pe_write_kernel (pe_write_kernel),
    .pe_weights      (pe_weights),
    .pe_ifmap        (pe_ifmap),
    .pe_psum         (pe_psum),
    .pe_sum          (pe_sum),
    .dbg_state       (dbg_state)
  );

  // ---------------- PE model: 3-tap window MAC, PE_LATENCY cycles ----------------
  logic signed [7:0]    h1, h2;
  logic [TAPS-1:0][7:0] w_q;
  logic signed [31:0]   pe_pipe [PE_LATENCY];
  logic signed [31:0]   win_sum;

  always_comb win_sum = pe_psum + $signed(w_q[0]) * h2 + $signed(w_q[1]) * h1
                        + $signed(w_q[2]) * pe_ifmap;

  always @(posedge clk) begin
    if (pe_rst) begin
      h1 <= '0;
      h2 <= '0;
      for (int i = 0; i < PE_LATENCY; i++) pe_pipe[i] <= '0;
    end else begin
      if (pe_write_kernel) w_q <= pe_weights;
      h1 <= pe_ifmap;
      h2 <= h1;
      pe_pipe[0] <= win_sum;
      for (int i = 1; i < PE_LATENCY; i++) pe_pipe[i] <= pe_pipe[i-1];
    end
  end
  assign pe_sum = pe_pipe[PE_LATENCY-1];

  // ---------------- monitor (samples on falling edge) ----------------
  int          cyc = 0;
  logic [31:0] got_q[$];
  int          got_cyc[$];
  logic        got_done[$];
  logic [7:0]  ifm_q[$];
  int          ifm_cyc[$];
  int          done_cnt = 0, prst_cnt = 0, wk_cnt = 0, both_cnt = 0, err_cnt = 0, busy_cnt = 0;

  always @(negedge clk) begin
    cyc++;
    if (host.out_valid) begin
      got_q.push_back(host.out_data);
      got_cyc.push_back(cyc);
      got_done.push_back(host.done);
    end
    if (pe_ifmap != 0) begin
      ifm_q.push_back(pe_ifmap);
      ifm_cyc.push_back(cyc);
    end
    if (host.done) done_cnt++;
    if (pe_rst) prst_cnt++;
    if (pe_write_kernel) wk_cnt++;
    if (pe_rst && pe_write_kernel) both_cnt++;
    if (host.err) err_cnt++;
    if (host.busy) busy_cnt++;
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [7:0]  row_data [8];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_row(input int len, input logic [23:0] kern, input logic [31:0] bias);
    host.row_len   = LW'(len);
    host.kernel_in = kern;
    host.bias_in   = bias;
    host.start     = 1'b1;
    tick();
    host.start     = 1'b0;
  endtask

  task automatic fill_row(input int len, input bit gap);
    int sent   = 0;
    int budget = 200;
    while (sent < len && budget > 0) begin
      host.in_valid = 1'b1;
      host.in_data  = row_data[sent];
      if (host.in_ready) sent++;
      tick();
      budget--;
      if (gap) begin
        host.in_valid = 1'b0;
        host.in_data  = 8'h55;
        tick();
        budget--;
      end
    end
    host.in_valid = 1'b0;
    host.in_data  = '0;
    check("fill_transfers", sent, len);
  endtask

  task automatic wait_idle();
    int budget = 100;
    while (host.busy && budget > 0) begin
      tick();
      budget--;
    end
    check("idle_timeout", (budget > 0), 1);
    tick();
  endtask

  task automatic check_results(input int base);
    int n = got_q.size() - base;
    check("result_count", n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      check("result_value", got_q[base+i], exp_q[i]);
      if (i > 0) check("result_consecutive", got_cyc[base+i] - got_cyc[base+i-1], 1);
    end
    if (n > 0) check("done_with_last", got_done[base+n-1], 1);
    if (n > 1) check("no_early_done", got_done[base+n-2], 0);
  endtask

  task automatic check_stream(input int base, input int len);
    int n = ifm_q.size() - base;
    check("stream_count", n, len);
    for (int i = 0; i < len && i < n; i++) begin
      check("stream_sample", ifm_q[base+i], row_data[i]);
      if (i > 0) check("stream_no_gap", ifm_cyc[base+i] - ifm_cyc[base+i-1], 1);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  int b_out, b_ifm, b_prst, b_wk, b_both, b_done, b_err, b_busy;

  initial begin
    rst            = 1'b1;
    host.start     = 1'b0;
    host.row_len   = '0;
    host.kernel_in = '0;
    host.bias_in   = '0;
    host.in_valid  = 1'b0;
    host.in_data   = '0;
    repeat (3) tick();

    // Reset values
    check("rst_in_ready", host.in_ready, 0);
    check("rst_out_valid", host.out_valid, 0);
    check("rst_busy", host.busy, 0);
    check("rst_done", host.done, 0);
    check("rst_err", host.err, 0);
    check("rst_pe_rst", pe_rst, 0);
    check("rst_pe_wk", pe_write_kernel, 0);
    check("rst_pe_ifmap", pe_ifmap, 0);
    check("rst_pe_psum", pe_psum, 0);
    check("rst_pe_weights", pe_weights, 0);
    check("rst_out_data", host.out_data, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;
    tick();

    // Row 1..5, kernel {1,2,3}, bias 0 -> 14, 20, 26
    row_data = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd0, 8'd0};
    exp_q = '{32'd14, 32'd20, 32'd26};
    b_out = got_q.size(); b_ifm = ifm_q.size(); b_prst = prst_cnt; b_wk = wk_cnt;
    b_both = both_cnt; b_done = done_cnt;
    start_row(5, {8'd3, 8'd2, 8'd1}, 32'd0);
    check("s1_busy", host.busy, 1);
    check("s1_clear_not_ready", host.in_ready, 0);
    fill_row(5, 1'b0);
    wait_idle();
    check_results(b_out);
    check_stream(b_ifm, 5);
    check("s1_pe_rst_cycles", prst_cnt - b_prst, 1);
    check("s1_pe_wk_cycles", wk_cnt - b_wk, 1);
    check("s1_strobe_overlap", both_cnt - b_both, 0);
    check("s1_done_pulses", done_cnt - b_done, 1);
    check("s1_weights", pe_weights, 32'h00030201);

    // Same row, bias 100; a start during the row must be ignored
    exp_q = '{32'd114, 32'd120, 32'd126};
    b_out = got_q.size(); b_err = err_cnt;
    start_row(5, {8'd3, 8'd2, 8'd1}, 32'd100);
    check("s2_psum", pe_psum, 100);
    host.row_len = LW'(2);
    host.start   = 1'b1;
    tick();
    host.start   = 1'b0;
    fill_row(5, 1'b0);
    wait_idle();
    check_results(b_out);
    check("s2_no_err_when_busy", err_cnt - b_err, 0);

    // in_valid toggling during FILL -> same results as the first row
    exp_q = '{32'd14, 32'd20, 32'd26};
    b_out = got_q.size(); b_ifm = ifm_q.size();
    start_row(5, {8'd3, 8'd2, 8'd1}, 32'd0);
    fill_row(5, 1'b1);
    wait_idle();
    check_results(b_out);
    check_stream(b_ifm, 5);

    // Illegal row lengths -> err pulse, no activity
    b_err = err_cnt; b_prst = prst_cnt; b_wk = wk_cnt; b_busy = busy_cnt;
    host.row_len = LW'(2);
    host.start   = 1'b1;
    tick();
    host.start   = 1'b0;
    check("s4_err_short", host.err, 1);
    check("s4_busy_short", host.busy, 0);
    tick();
    check("s4_err_one_cycle", host.err, 0);
    host.row_len = LW'(MAX_ROW + 1);
    host.start   = 1'b1;
    tick();
    host.start   = 1'b0;
    check("s4_err_long", host.err, 1);
    check("s4_busy_long", host.busy, 0);
    repeat (2) tick();
    check("s4_err_pulses", err_cnt - b_err, 2);
    check("s4_no_pe_rst", prst_cnt - b_prst, 0);
    check("s4_no_pe_wk", wk_cnt - b_wk, 0);
    check("s4_never_busy", busy_cnt - b_busy, 0);

    // Reset during STREAM, then row 5,5,5 with kernel {1,1,1} -> only 15
    start_row(5, {8'd3, 8'd2, 8'd1}, 32'd0);
    fill_row(5, 1'b0);
    tick();
    check("s5_in_stream", dbg_state, 4);
    b_out = got_q.size();
    rst = 1'b1;
    #1;
    check("s5_async_busy", host.busy, 0);
    check("s5_async_ifmap", pe_ifmap, 0);
    check("s5_async_psum", pe_psum, 0);
    tick();
    rst = 1'b0;
    repeat (15) tick();
    check("s5_no_stale_out", got_q.size() - b_out, 0);

    row_data = '{8'd5, 8'd5, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    exp_q = '{32'd15};
    b_out = got_q.size(); b_ifm = ifm_q.size(); b_prst = prst_cnt; b_done = done_cnt;
    start_row(3, {8'd1, 8'd1, 8'd1}, 32'd0);
    fill_row(3, 1'b0);
    wait_idle();
    check_results(b_out);
    check_stream(b_ifm, 3);
    check("s5_clear_before_result", prst_cnt - b_prst, 1);
    check("s5_done_pulses", done_cnt - b_done, 1);
    if (got_q.size() > b_out && ifm_q.size() > b_ifm + 2)
      check("s5_latency", got_cyc[b_out] - ifm_cyc[b_ifm+2], PE_LATENCY + 1);
    else
      check("s5_latency_present", 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
